// File: rtl/conv_window_gen.sv
// Streaming 5x5 window generator for the convolution datapath.
// Four line buffers feed a shift-left window register, one pixel per cycle.
module conv_window_gen #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [7:0]              pixel_in,
    input  logic                           pixel_valid,
    output logic signed [4:0][4:0][7:0]    window,
    output logic                           window_valid,
    output logic                           frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic signed [4:0][4:0][7:0] win_q, win_d;
    logic                        wv_q, wv_d;
    logic                        fd_q, fd_d;

    logic [7:0]      lb_q [4][IMG_W];
    logic [4:0][7:0] colv;

    logic accept;
    logic last_col;
    logic last_row;

    assign accept   = pixel_valid && !rst;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));

    // Oldest row at index 0, incoming pixel at index 4.
    always_comb begin
        colv    = '0;
        colv[0] = lb_q[3][col_q];
        colv[1] = lb_q[2][col_q];
        colv[2] = lb_q[1][col_q];
        colv[3] = lb_q[0][col_q];
        colv[4] = pixel_in;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        win_d = win_q;
        wv_d  = 1'b0;
        fd_d  = 1'b0;
        if (pixel_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
                win_d[i][4] = colv[i];
            end
            wv_d = (row_q >= RW'(4)) && (col_q >= CW'(4));
            fd_d = last_col && last_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            win_q <= '0;
            wv_q  <= 1'b0;
            fd_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_d;
            wv_q  <= wv_d;
            fd_q  <= fd_d;
        end
    end

    // Line buffers hold pixel data only, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[3][col_q] <= lb_q[2][col_q];
            lb_q[2][col_q] <= lb_q[1][col_q];
            lb_q[1][col_q] <= lb_q[0][col_q];
            lb_q[0][col_q] <= pixel_in;
        end
    end

    assign window       = win_q;
    assign window_valid = wv_q;
    assign frame_done   = fd_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 8x8 scenario table plus
// reset-mid-frame and 5x5 minimum-size sequences.
module tb_conv_window_gen;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_a, pv_a, wv_a, fd_a;
    logic [7:0]               pix_a;
    logic [4:0][4:0][7:0]     win_a;
    logic                     rst_b, pv_b, wv_b, fd_b;
    logic [7:0]               pix_b;
    logic [4:0][4:0][7:0]     win_b;

    conv_window_gen #(.IMG_W(8), .IMG_H(8)) dut_a (
        .clk(clk), .rst(rst_a), .pixel_in(pix_a), .pixel_valid(pv_a),
        .window(win_a), .window_valid(wv_a), .frame_done(fd_a)
    );

    conv_window_gen #(.IMG_W(5), .IMG_H(5)) dut_b (
        .clk(clk), .rst(rst_b), .pixel_in(pix_b), .pixel_valid(pv_b),
        .window(win_b), .window_valid(wv_b), .frame_done(fd_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor for the 8x8 instance.
    int acc_a = 0;
    bit pv_edge_a = 0;
    bit rst_edge_a = 0;
    bit prev_wv_a = 0;
    int hold_viol = 0;
    int consec_a = 0;
    int fdcnt_a = 0;
    logic [4:0][4:0][7:0] prev_w_a;
    logic [4:0][4:0][7:0] capW[$];
    int capIdx[$];
    bit capFd[$];

    always @(posedge clk) begin
        pv_edge_a = pv_a && !rst_a;
        rst_edge_a = rst_a;
        if (pv_edge_a) acc_a++;
    end

    always @(negedge clk) begin
        if (!pv_edge_a && !rst_edge_a &&
            (win_a != prev_w_a || wv_a || fd_a)) hold_viol++;
        if (wv_a && prev_wv_a) consec_a++;
        if (wv_a) begin
            capW.push_back(win_a);
            capIdx.push_back(acc_a - 1);
            capFd.push_back(fd_a);
        end
        if (fd_a) fdcnt_a++;
        prev_wv_a = wv_a;
        prev_w_a = win_a;
    end

    // Monitor for the 5x5 instance.
    int acc_b = 0;
    int fdcnt_b = 0;
    logic [4:0][4:0][7:0] capBW[$];
    int capBIdx[$];
    bit capBFd[$];

    always @(posedge clk) begin
        if (pv_b && !rst_b) acc_b++;
    end

    always @(negedge clk) begin
        if (wv_b) begin
            capBW.push_back(win_b);
            capBIdx.push_back(acc_b - 1);
            capBFd.push_back(fd_b);
        end
        if (fd_b) fdcnt_b++;
    end

    task automatic step_a(input logic [7:0] p, input bit v, input bit r);
        pix_a = p;
        pv_a = v;
        rst_a = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [7:0] p, input bit v, input bit r);
        pix_b = p;
        pv_b = v;
        rst_b = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_pix(int kind, int f, int r, int c);
        int v;
        case (kind)
            0: v = r * 8 + c;
            1: v = (f == 0) ? r * 8 + c : (r * 8 + c + 64) % 128;
            default: v = ((r + c) % 2 == 0) ? 128 : 127;
        endcase
        return 8'(v);
    endfunction

    task automatic check_model(input string tag, input int qb,
                               input int nw, input int kind);
        logic [4:0][4:0][7:0] w;
        int f, kk, r, c;
        for (int k = 0; k < nw; k++) begin
            w = capW[qb + k];
            f = k / 16;
            kk = k % 16;
            r = 4 + kk / 4;
            c = 4 + kk % 4;
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    chk($sformatf("%s win%0d[%0d][%0d]", tag, k, i, j),
                        int'(w[i][j]),
                        int'(exp_pix(kind, f, r - 4 + i, c - 4 + j)));
        end
    endtask

    typedef struct {
        int kind;
        int gap;
        int nfr;
        int nwin;
        int first_idx;
        int w00;
        int w23;
        int w44;
        int last00;
        int last44;
        int fdcnt;
        int f2_idx;
        int f2_w44;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [4:0][4:0][7:0] w;
        int qb, fb, cb, ab, nw, lst;
        string tag;

        tbl[0] = '{0, 0, 1, 16, 36, 0, 19, 36, 27, 63, 1, -1, -1};
        tbl[1] = '{0, 1, 1, 16, 36, 0, 19, 36, 27, 63, 1, -1, -1};
        tbl[2] = '{1, 0, 2, 32, 36, 0, 19, 36, 91, 127, 2, 100, 100};
        tbl[3] = '{2, 0, 1, 16, 36, 128, 127, 128, 128, 128, 1, -1, -1};

        rst_a = 1'b1; pv_a = 1'b0; pix_a = '0;
        rst_b = 1'b1; pv_b = 1'b0; pix_b = '0;
        @(posedge clk);
        #1;
        step_a(8'h00, 1'b0, 1'b1);
        rst_b = 1'b0;
        chk("rst_a win_nonzero", int'(win_a != '0), 0);
        chk("rst_a window_valid", int'(wv_a), 0);
        chk("rst_a frame_done", int'(fd_a), 0);
        chk("rst_b win_nonzero", int'(win_b != '0), 0);
        chk("rst_b window_valid", int'(wv_b), 0);
        chk("rst_b frame_done", int'(fd_b), 0);

        for (int s = 0; s < 4; s++) begin
            tag = $sformatf("s%0d", s);
            qb = capW.size();
            fb = fdcnt_a;
            cb = consec_a;
            ab = acc_a;
            for (int f = 0; f < tbl[s].nfr; f++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        step_a(exp_pix(tbl[s].kind, f, r, c), 1'b1, 1'b0);
                        if (tbl[s].gap != 0) step_a(8'h55, 1'b0, 1'b0);
                    end
            repeat (3) step_a(8'h00, 1'b0, 1'b0);
            nw = capW.size() - qb;
            chk({tag, " nwin"}, nw, tbl[s].nwin);
            chk({tag, " frame_done count"}, fdcnt_a - fb, tbl[s].fdcnt);
            if (nw > 0) begin
                w = capW[qb];
                chk({tag, " first idx"}, capIdx[qb] - ab, tbl[s].first_idx);
                chk({tag, " first w00"}, int'(w[0][0]), tbl[s].w00);
                chk({tag, " first w23"}, int'(w[2][3]), tbl[s].w23);
                chk({tag, " first w44"}, int'(w[4][4]), tbl[s].w44);
                lst = qb + nw - 1;
                w = capW[lst];
                chk({tag, " last w00"}, int'(w[0][0]), tbl[s].last00);
                chk({tag, " last w44"}, int'(w[4][4]), tbl[s].last44);
                chk({tag, " last frame_done"}, int'(capFd[lst]), 1);
            end
            if (tbl[s].f2_idx >= 0 && nw > 16) begin
                w = capW[qb + 16];
                chk({tag, " f2 first idx"}, capIdx[qb + 16] - ab, tbl[s].f2_idx);
                chk({tag, " f2 first w44"}, int'(w[4][4]), tbl[s].f2_w44);
            end
            if (tbl[s].gap != 0)
                chk({tag, " consecutive valid"}, consec_a - cb, 0);
            check_model(tag, qb, (nw < tbl[s].nwin) ? nw : tbl[s].nwin,
                        tbl[s].kind);
        end

        // Reset after 30 pixels, with pixel_valid high on the reset edge.
        for (int n = 0; n < 30; n++)
            step_a(8'(n), 1'b1, 1'b0);
        step_a(8'd30, 1'b1, 1'b1);
        chk("midrst win_nonzero", int'(win_a != '0), 0);
        chk("midrst window_valid", int'(wv_a), 0);
        chk("midrst frame_done", int'(fd_a), 0);
        qb = capW.size();
        fb = fdcnt_a;
        ab = acc_a;
        for (int n = 0; n < 64; n++)
            step_a(8'(n), 1'b1, 1'b0);
        repeat (3) step_a(8'h00, 1'b0, 1'b0);
        nw = capW.size() - qb;
        chk("midrst nwin", nw, 16);
        chk("midrst frame_done count", fdcnt_a - fb, 1);
        if (nw > 0)
            chk("midrst first idx", capIdx[qb] - ab, 36);
        check_model("midrst", qb, (nw < 16) ? nw : 16, 0);

        // Minimum 5x5 image: a single window.
        for (int n = 0; n < 25; n++)
            step_b(8'(n), 1'b1, 1'b0);
        repeat (3) step_b(8'h00, 1'b0, 1'b0);
        chk("min nwin", capBW.size(), 1);
        chk("min frame_done count", fdcnt_b, 1);
        if (capBW.size() > 0) begin
            w = capBW[0];
            chk("min idx", capBIdx[0], 24);
            chk("min frame_done coincident", int'(capBFd[0]), 1);
            chk("min w00", int'(w[0][0]), 0);
            chk("min w22", int'(w[2][2]), 12);
            chk("min w41", int'(w[4][1]), 21);
            chk("min w44", int'(w[4][4]), 24);
        end

        chk("hold violations", hold_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 5x5 sliding-window generator that produces the input window for the 5x5 convolution datapath. It accepts one signed 8-bit pixel per cycle in raster order and buffers the previous four image rows in line buffers. For every pixel that completes a full 5x5 neighbourhood, it presents that neighbourhood as a window array, so one window is available per valid output position ("valid" convolution, no padding).

## Interface

Parameters:
- IMG_W, default 32: image width in pixels; legal values ≥ 5.
- IMG_H, default 32: image height in pixels; legal values ≥ 5.

Ports:
- clk, input, 1: sole clock; all logic is rising-edge.
- rst, input, 1: reset, synchronous and active-high.
- pixel_in, input, 8 signed: incoming pixel, raster order (row-major, left to right, top to bottom).
- pixel_valid, input, 1: pixel_in is accepted on any clk edge where this is high. There is no backpressure.
- window, output, [4:0][4:0] x 8 signed: current window. window[i][j] is row i from the top and column j from the left.
- window_valid, output, 1: one-cycle pulse; window holds a new complete neighbourhood.
- frame_done, output, 1: one-cycle pulse coincident with acceptance of the last pixel (IMG_H-1, IMG_W-1) of a frame being reflected at the output.

## Operation

- Counters:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1.
  - Both advance only on accepted pixels.
  - col wraps to 0 and increments row. Row wraps to 0 after (IMG_H-1, IMG_W-1), and the next frame begins immediately with no idle cycle required.
- Line buffers:
  - There are four buffers, each IMG_W entries deep, addressed by col.
  - On each accepted pixel at column c, the column vector is formed as: LB3[c] (oldest row, r-4), then LB2[c], LB1[c], LB0[c], then pixel_in (row r).
  - The buffers then cascade: LB3[c]←LB2[c], LB2[c]←LB1[c], LB1[c]←LB0[c], LB0[c]←pixel_in.
  - Line-buffer contents are not reset.
- Window register:
  - On each accepted pixel, columns shift left: window[i][j]←window[i][j+1] for j=0..3.
  - The new column vector loads into window[i][4], where i=0 is the oldest row and i=4 is pixel_in.
  - With no accepted pixel, the window holds its value.
- Output position: after accepting pixel (r, c) with r≥4 and c≥4, window[i][j] = pixel(r-4+i, c-4+j).
- Windows per frame: exactly (IMG_W-4)*(IMG_H-4).
- Stale data: windows straddling a row boundary (c<4) or formed from the previous frame (r<4) are never flagged valid.
- Arithmetic: none. Values pass through bit-exact, with the sign preserved.

## Timing

- Reset values: window all zeros, window_valid=0, frame_done=0, row=0, col=0.
- Latency: 1 cycle. If pixel_valid is high at edge N for pixel (r, c), then after edge N the outputs are:
  - window_valid=1 iff r≥4 and c≥4;
  - window updated;
  - frame_done=1 iff (r, c)=(IMG_H-1, IMG_W-1).
- Pulse widths: window_valid and frame_done are high for exactly one cycle per qualifying pixel and are low in any cycle following an edge with pixel_valid=0.
- Throughput: one pixel per cycle sustained; any gap pattern in pixel_valid is legal.
- frame_done and window_valid are both high after the last pixel of a frame.
- Reset mid-frame:
  - On the reset edge, the counters return to 0 and both output flags clear.
  - An asserted pixel_valid on the same edge is ignored.
  - The next accepted pixel is treated as (0, 0).
- The downstream datapath samples window on the cycle window_valid is high. The window is stable until the next accepted pixel.

## Test plan

- Ramp frame, IMG_W=IMG_H=8, pixel = r*8+c, pixel_valid continuous. Required response:
  - the first window_valid follows pixel 36;
  - window[0][0]=0, window[2][3]=19, window[4][4]=36;
  - 16 windows total;
  - the last window has window[0][0]=27 and window[4][4]=63, with frame_done high in the same cycle.
- Same ramp with pixel_valid toggling 1,0,1,0 -> identical window sequence and count; window_valid never high in two consecutive cycles; window holds during gaps.
- Two back-to-back frames, where frame 2 = frame 1 + 64 (mod 128, signed) -> frame 2 produces 16 windows with no window_valid during its rows 0–3; its first window has window[4][4]=100.
- Signed values: pixel = -128 for even (r+c), 127 otherwise -> every window element matches, sign-exact, the checkerboard pattern.
- rst asserted for 1 cycle after 30 pixels, with pixel_valid high on the reset edge, then a full fresh frame -> outputs zero the cycle after reset; exactly 16 windows and one frame_done from the fresh frame.
- IMG_W=5, IMG_H=5 minimum size -> exactly one window, after pixel 24, with window_valid and frame_done high together.
